// File: rtl/iob_lat_mem.sv
// IOb subordinate memory model: byte-enable writes, RD_LAT-cycle pipelined reads,
// periodic ready backpressure and saturating read/write transaction counters.
module iob_lat_mem #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int RD_LAT       = 1,
    parameter int STALL_PERIOD = 0,
    parameter int STALL_LEN    = 0,
    parameter int CNT_W        = 32,
    localparam int NBYTES      = DATA_W / 8,
    localparam int NBYTES_W    = $clog2(NBYTES),
    localparam int MEM_W       = ADDR_W - NBYTES_W
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_n_i,
    input  logic              iob_valid_i,
    input  logic [ADDR_W-1:0] iob_addr_i,
    input  logic [DATA_W-1:0] iob_wdata_i,
    input  logic [NBYTES-1:0] iob_wstrb_i,
    output logic              iob_rvalid_o,
    output logic [DATA_W-1:0] iob_rdata_o,
    output logic              iob_ready_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  rd_cnt_o,
    output logic [CNT_W-1:0]  wr_cnt_o
);

    localparam int SC_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    logic [SC_W-1:0]   sc;
    logic              acc;
    logic              rd_acc;
    logic              wr_acc;
    logic [MEM_W-1:0]  widx;
    logic [DATA_W-1:0] mem [2**MEM_W];
    logic [RD_LAT-1:0] vld_p;
    logic [DATA_W-1:0] dat_p [RD_LAT];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign iob_ready_o = (STALL_PERIOD == 0) || (32'(sc) >= STALL_LEN);
    assign acc         = iob_valid_i & iob_ready_o & cke_i;
    assign rd_acc      = acc & ~(|iob_wstrb_i);
    assign wr_acc      = acc & (|iob_wstrb_i);
    assign widx        = iob_addr_i[ADDR_W-1:NBYTES_W];

    generate
        if (NBYTES_W > 0) begin : g_lsb
            // Byte offset within the word does not select anything.
            logic unused_lsb;
            assign unused_lsb = ^iob_addr_i[NBYTES_W-1:0];
        end
    endgenerate

    // Control: stall counter, read-valid pipeline, transaction counters
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sc       <= '0;
            vld_p    <= '0;
            rd_cnt_o <= '0;
            wr_cnt_o <= '0;
        end else if (cke_i) begin
            if (STALL_PERIOD != 0) begin
                sc <= (sc == SC_W'(STALL_PERIOD - 1)) ? '0 : sc + 1'b1;
            end
            vld_p[0] <= rd_acc;
            for (int s = 1; s < RD_LAT; s++) begin
                vld_p[s] <= vld_p[s-1];
            end
            if (rd_acc) rd_cnt_o <= sat_inc(rd_cnt_o);
            if (wr_acc) wr_cnt_o <= sat_inc(wr_cnt_o);
        end
    end

    // Data: storage and read-data pipeline carry no reset; output is gated by valid
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rd_acc) dat_p[0] <= mem[widx];
            for (int s = 1; s < RD_LAT; s++) begin
                dat_p[s] <= dat_p[s-1];
            end
            if (wr_acc) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (iob_wstrb_i[b]) mem[widx][b*8 +: 8] <= iob_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign iob_rvalid_o = vld_p[RD_LAT-1];
    assign iob_rdata_o  = vld_p[RD_LAT-1] ? dat_p[RD_LAT-1] : '0;
    assign busy_o       = |vld_p;

endmodule

// File: tb/tb_iob_lat_mem.sv
// Bench for iob_lat_mem: three instances (latency 1 / 4 / 3 with stalls) driven by directed
// and random traffic, checked against a schedule-based reference model.
module tb_iob_lat_mem;

    localparam int LAT [3] = '{1, 4, 3};
    localparam int P   [3] = '{0, 0, 5};
    localparam int L   [3] = '{0, 0, 2};
    localparam int CW  [3] = '{3, 32, 32};

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic [2:0] cke, valid, rvalid, ready, busy;
    logic [2:0][15:0] addr;
    logic [2:0][31:0] wdata, rdata, rd_cnt, wr_cnt;
    logic [2:0][3:0]  wstrb;
    logic [2:0] rd_cnt0, wr_cnt0;

    assign rd_cnt[0] = {29'd0, rd_cnt0};
    assign wr_cnt[0] = {29'd0, wr_cnt0};

    always #5 clk = ~clk;

    iob_lat_mem #(.RD_LAT(1), .CNT_W(3)) u0 (
        .clk_i(clk), .cke_i(cke[0]), .arst_n_i(rst_n), .iob_valid_i(valid[0]),
        .iob_addr_i(addr[0]), .iob_wdata_i(wdata[0]), .iob_wstrb_i(wstrb[0]),
        .iob_rvalid_o(rvalid[0]), .iob_rdata_o(rdata[0]), .iob_ready_o(ready[0]),
        .busy_o(busy[0]), .rd_cnt_o(rd_cnt0), .wr_cnt_o(wr_cnt0));

    iob_lat_mem #(.RD_LAT(4)) u1 (
        .clk_i(clk), .cke_i(cke[1]), .arst_n_i(rst_n), .iob_valid_i(valid[1]),
        .iob_addr_i(addr[1]), .iob_wdata_i(wdata[1]), .iob_wstrb_i(wstrb[1]),
        .iob_rvalid_o(rvalid[1]), .iob_rdata_o(rdata[1]), .iob_ready_o(ready[1]),
        .busy_o(busy[1]), .rd_cnt_o(rd_cnt[1]), .wr_cnt_o(wr_cnt[1]));

    iob_lat_mem #(.RD_LAT(3), .STALL_PERIOD(5), .STALL_LEN(2)) u2 (
        .clk_i(clk), .cke_i(cke[2]), .arst_n_i(rst_n), .iob_valid_i(valid[2]),
        .iob_addr_i(addr[2]), .iob_wdata_i(wdata[2]), .iob_wstrb_i(wstrb[2]),
        .iob_rvalid_o(rvalid[2]), .iob_rdata_o(rdata[2]), .iob_ready_o(ready[2]),
        .busy_o(busy[2]), .rd_cnt_o(rd_cnt[2]), .wr_cnt_o(wr_cnt[2]));

    // Reference model: word-level memory plus a table of which tick each read must appear on.
    logic [31:0] mm  [3][64];
    logic        sv  [3][16];
    logic [31:0] sd  [3][16];
    int          tick [3];
    int          pend [3];
    logic        e_rv [3];
    logic        e_bz [3];
    logic [31:0] e_rd [3];
    logic [31:0] e_rc [3];
    logic [31:0] e_wc [3];
    logic [2:0]  acc_l;
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input int i, input logic [31:0] c);
        logic [31:0] mx;
        mx = (CW[i] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CW[i]) - 32'd1);
        return (c == mx) ? c : c + 32'd1;
    endfunction

    function automatic logic exp_ready(input int i);
        if (P[i] == 0) return 1'b1;
        return (tick[i] % P[i]) >= L[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < 16; s++) sv[i][s] = 1'b0;
            tick[i] = 0; pend[i] = 0;
            e_rv[i] = 1'b0; e_bz[i] = 1'b0; e_rd[i] = '0; e_rc[i] = '0; e_wc[i] = '0;
        end
    endtask

    task automatic step();
        logic [2:0] cnt;
        int w, slot;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d.ready", i), 32'(ready[i]), 32'(exp_ready(i)));
            cnt[i]   = cke[i] & rst_n;
            acc_l[i] = valid[i] & exp_ready(i) & cnt[i];
            if (acc_l[i]) begin
                w = int'(addr[i][7:2]);
                if (wstrb[i] == 4'd0) begin
                    slot = (tick[i] + LAT[i]) % 16;
                    sv[i][slot] = 1'b1;
                    sd[i][slot] = mm[i][w];
                    pend[i]++;
                    e_rc[i] = sat(i, e_rc[i]);
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (wstrb[i][b]) mm[i][w][8*b +: 8] = wdata[i][8*b +: 8];
                    e_wc[i] = sat(i, e_wc[i]);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (cnt[i]) begin
                tick[i]++;
                slot = tick[i] % 16;
                e_bz[i] = (pend[i] != 0);
                if (sv[i][slot]) begin
                    e_rv[i] = 1'b1; e_rd[i] = sd[i][slot]; sv[i][slot] = 1'b0; pend[i]--;
                end else begin
                    e_rv[i] = 1'b0; e_rd[i] = '0;
                end
            end
            chk($sformatf("u%0d.rvalid", i), 32'(rvalid[i]), 32'(e_rv[i]));
            chk($sformatf("u%0d.rdata", i), rdata[i], e_rd[i]);
            chk($sformatf("u%0d.busy", i), 32'(busy[i]), 32'(e_bz[i]));
            chk($sformatf("u%0d.rd_cnt", i), rd_cnt[i], e_rc[i]);
            chk($sformatf("u%0d.wr_cnt", i), wr_cnt[i], e_wc[i]);
        end
    endtask

    task automatic do_reset();
        valid = '0;
        rst_n = 1'b0;
        #1;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic xact(input int i, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        valid[i] = 1'b1; addr[i] = a; wdata[i] = d; wstrb[i] = s;
        do begin
            step();
            n++;
        end while (!acc_l[i] && n < 20);
        chk($sformatf("u%0d.accept_timeout", i), 32'(acc_l[i]), 32'd1);
        valid[i] = 1'b0;
    endtask

    task automatic wait_rv(input int i, output logic [31:0] d);
        int n;
        n = 0;
        while (rvalid[i] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk($sformatf("u%0d.rvalid_timeout", i), 32'(rvalid[i]), 32'd1);
        d = rdata[i];
    endtask

    initial begin
        logic [31:0] d;
        int n_acc;
        cke = '1; valid = '0; addr = '0; wdata = '0; wstrb = '0;
        for (int i = 0; i < 3; i++)
            for (int w = 0; w < 64; w++) mm[i][w] = '0;
        model_reset();
        #1;
        do_reset();
        chk("reset.u2.ready", 32'(ready[2]), 32'd0);
        chk("reset.u0.ready", 32'(ready[0]), 32'd1);

        // Single write then read, latency 1
        xact(0, 16'h0010, 32'hDEADBEEF, 4'hF);
        xact(0, 16'h0010, 32'h0, 4'h0);
        chk("lat1.rvalid", 32'(rvalid[0]), 32'd1);
        chk("lat1.rdata", rdata[0], 32'hDEADBEEF);
        chk("lat1.wr_cnt", wr_cnt[0], 32'd1);
        chk("lat1.rd_cnt", rd_cnt[0], 32'd1);
        step();
        chk("lat1.pulse", 32'(rvalid[0]), 32'd0);
        chk("lat1.rdata_zero", rdata[0], 32'd0);

        // Byte strobes
        xact(0, 16'h0020, 32'h11223344, 4'hF);
        xact(0, 16'h0020, 32'hAABBCCDD, 4'h5);
        xact(0, 16'h0021, 32'h0, 4'h0);
        chk("wstrb.rdata", rdata[0], 32'h11BB33DD);

        // Write counter saturates at 7 on the 3-bit instance
        for (int k = 0; k < 6; k++) xact(0, 16'h0030, 32'(k), 4'hF);
        chk("sat.wr_cnt", wr_cnt[0], 32'd7);

        // Latency 4, back-to-back reads
        for (int k = 0; k < 4; k++) xact(1, 16'(4 * k), 32'(k + 1), 4'hF);
        for (int k = 0; k < 3; k++) xact(1, 16'(4 * k), 32'h0, 4'h0);
        chk("lat4.early", 32'(rvalid[1]), 32'd0);
        xact(1, 16'h000C, 32'h0, 4'h0);
        chk("lat4.first_rvalid", 32'(rvalid[1]), 32'd1);
        wait_rv(1, d);
        chk("lat4.data1", d, 32'd1);
        for (int k = 2; k <= 4; k++) begin
            step();
            chk("lat4.rvalid", 32'(rvalid[1]), 32'd1);
            chk("lat4.data", rdata[1], 32'(k));
            chk("lat4.busy", 32'(busy[1]), 32'd1);
        end
        step();
        chk("lat4.idle", 32'(busy[1]), 32'd0);

        // Read-then-write hazard on the stalling latency-3 instance
        xact(2, 16'h0040, 32'h5, 4'hF);
        xact(2, 16'h0040, 32'h0, 4'h0);
        xact(2, 16'h0040, 32'h9, 4'hF);
        wait_rv(2, d);
        chk("hazard.old", d, 32'h5);
        xact(2, 16'h0040, 32'h0, 4'h0);
        wait_rv(2, d);
        chk("hazard.new", d, 32'h9);

        // Stall pattern from reset with valid held high
        do_reset();
        valid[2] = 1'b1; addr[2] = 16'h0040; wstrb[2] = 4'h0;
        n_acc = 0;
        for (int k = 0; k < 10; k++) begin
            chk("stall.ready", 32'(ready[2]), 32'((k % 5) >= 2));
            step();
            n_acc += int'(acc_l[2]);
        end
        valid[2] = 1'b0;
        chk("stall.rd_cnt", rd_cnt[2], 32'd6);
        for (int k = 0; k < 5; k++) step();

        // Reset with two reads in flight
        xact(1, 16'h0000, 32'h0, 4'h0);
        xact(1, 16'h0004, 32'h0, 4'h0);
        chk("rstmid.busy", 32'(busy[1]), 32'd1);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rstmid.rvalid", 32'(rvalid[1]), 32'd0);
        end
        chk("rstmid.rd_cnt", rd_cnt[1], 32'd0);
        xact(1, 16'h0008, 32'h0, 4'h0);
        wait_rv(1, d);
        chk("rstmid.retained", d, 32'd3);

        // Clock enable low freezes an in-flight read
        step();
        xact(1, 16'h000C, 32'h0, 4'h0);
        cke[1] = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("cke.frozen", 32'(rvalid[1]), 32'd0);
        cke[1] = 1'b1;
        wait_rv(1, d);
        chk("cke.data", d, 32'd4);
        step();

        // Preload every model word, then random traffic
        for (int w = 0; w < 64; w++)
            for (int i = 0; i < 3; i++) xact(i, 16'(4 * w), $urandom, 4'hF);
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 3; i++) begin
                valid[i] = 1'($urandom_range(0, 1));
                addr[i]  = {8'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
                wdata[i] = $urandom;
                wstrb[i] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                cke[i]   = ($urandom_range(0, 7) != 0);
            end
            step();
        end
        valid = '0;
        cke   = '1;
        for (int k = 0; k < 8; k++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
